vertex_post_processor: RTL and testbench
========================================

Name: vertex_post_processor

Overview:
- Sits directly downstream of the vertex shader.
- Accepts one clip-space vertex (x, y, z, w) in signed fixed point and runs a clip-space trivial-reject test.
- Performs the perspective divide with an iterative reciprocal, then applies the viewport transform.
- Emits integer screen coordinates plus an NDC depth value to the rasterizer set-up stage. One vertex is in flight at a time; the upstream stage is throttled by o_ready.

Parameters:
- DATAWIDTH, 18, total bits of signed fixed-point values (Q(DATAWIDTH-FRACBITS).FRACBITS)
- FRACBITS, 12, fractional bits; 1.0 = 2^FRACBITS
- SCREEN_WIDTH, 320, horizontal resolution in pixels
- SCREEN_HEIGHT, 240, vertical resolution in pixels

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_vertex  in  DATAWIDTH x4 (signed)  clip-space x, y, z, w in indices 0..3
- i_dv  in  1  input vertex valid
- i_last  in  1  marks the final vertex of the current model
- o_ready  out  1  block can accept a vertex this cycle
- o_x  out  $clog2(SCREEN_WIDTH)  screen x, unsigned pixel
- o_y  out  $clog2(SCREEN_HEIGHT)  screen y, unsigned pixel, 0 at top
- o_depth  out  DATAWIDTH (signed)  NDC z = z/w
- o_clipped  out  1  vertex failed clip test
- o_dv  out  1  output valid, one-cycle pulse
- o_finished  out  1  one-cycle pulse, coincident with o_dv of the i_last vertex

Behaviour:
- Reset: async assert forces state IDLE. Outputs: o_ready=1, o_dv=0, o_finished=0, o_clipped=0, o_x=o_y=o_depth=0. Reset mid-operation aborts the vertex with no output.
- Acceptance:
  - Vertex accepted on a rising edge where i_dv && o_ready; x, y, z, w and i_last are registered.
  - i_dv while o_ready=0 is ignored; upstream must hold the vertex.
  - No downstream backpressure.
- States and transitions:
  - IDLE: o_ready=1. Goes to DIVIDE on accept.
  - DIVIDE: exactly 2*FRACBITS+1 cycles. Restoring division inv_w = floor(2^(2*FRACBITS) / w), one quotient bit per cycle. Then goes to MULTIPLY.
  - MULTIPLY: 1 cycle. x_ndc, y_ndc, z_ndc = (coord * inv_w) >>> FRACBITS. The full 2*DATAWIDTH product is kept, then saturated to DATAWIDTH bits. Then goes to MAP.
  - MAP: 1 cycle.
    - sx = ((x_ndc + ONE) * (SCREEN_WIDTH/2)) >>> FRACBITS
    - sy = ((ONE - y_ndc) * (SCREEN_HEIGHT/2)) >>> FRACBITS
    - Both clamped to [0, SCREEN_WIDTH-1] and [0, SCREEN_HEIGHT-1].
    - Then goes to OUTPUT.
  - OUTPUT: o_dv=1 and o_ready=1 for one cycle. A new vertex may be accepted in this cycle (goes to DIVIDE), otherwise returns to IDLE.
- Latency: accept edge N gives o_dv high in the cycle after edge N+2*FRACBITS+3. With defaults that is 28 cycles; maximum throughput is one vertex per 28 cycles.
- o_x, o_y, o_depth, o_clipped hold their values until the next o_dv.
- Reciprocal saturation: if the quotient exceeds 2^(DATAWIDTH-1)-1, inv_w saturates to 2^(DATAWIDTH-1)-1.
- Clip test, evaluated on the registered input:
  - o_clipped=1 if w<=0, |x|>w, |y|>w, or |z|>w.
  - |x|==w is not clipped.
- w<=0: the divider is still run for the fixed latency (latency never varies). The result is forced to zero, giving o_x=SCREEN_WIDTH/2, o_y=SCREEN_HEIGHT/2, o_depth=0, o_clipped=1.
- o_finished: asserted with o_dv only if the registered i_last was 1.

Test Plan:
- Reset then idle -> o_ready=1, o_dv=0, all outputs 0. Asserting rst during DIVIDE -> no o_dv ever issued for that vertex; o_ready=1 after release.
- Defaults, x=2048, y=0, z=2048, w=4096 -> o_dv exactly 28 cycles after accept; o_x=240, o_y=120, o_depth=2048, o_clipped=0.
- x=-8192, y=4096, z=0, w=8192 -> inv_w=2048; o_x=0, o_y=60, o_depth=0, o_clipped=0.
- x=4096, y=0, z=0, w=4096 (x_ndc=1.0) -> o_x=319 (clamped), o_y=120, o_clipped=0. Same vertex with x=4100 -> o_clipped=1, o_x=319.
- w=0 and w=-4096 -> o_clipped=1, o_x=160, o_y=120, o_depth=0, latency still 28 cycles. w=1 with x=0 -> inv_w saturates to 131071, o_x=160.
- Three vertices driven back-to-back with i_dv held high, last with i_last=1 -> each accepted in the previous vertex's OUTPUT cycle; o_dv pulses spaced 28 cycles apart; o_finished high only with the third o_dv.

Source files
------------

// File: rtl/vertex_post_processor.sv
// Vertex post-processor: clip-space trivial-reject test, perspective divide
// through a bit-serial restoring reciprocal, and viewport mapping to pixels.
module vertex_post_processor #(
  parameter int DATAWIDTH     = 18,
  parameter int FRACBITS      = 12,
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 240
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic signed [DATAWIDTH-1:0]        i_vertex [4],
  input  logic                               i_dv,
  input  logic                               i_last,
  output logic                               o_ready,
  output logic [$clog2(SCREEN_WIDTH)-1:0]    o_x,
  output logic [$clog2(SCREEN_HEIGHT)-1:0]   o_y,
  output logic signed [DATAWIDTH-1:0]        o_depth,
  output logic                               o_clipped,
  output logic                               o_dv,
  output logic                               o_finished
);

  localparam int DW = DATAWIDTH;
  localparam int FB = FRACBITS;
  localparam int QW = 2 * FB + 1;            // quotient bits of 2^(2*FB) / w
  localparam int CW = $clog2(QW);
  localparam int XW = $clog2(SCREEN_WIDTH);
  localparam int YW = $clog2(SCREEN_HEIGHT);

  localparam logic [CW-1:0]           DIV_LAST = CW'(QW - 1);
  localparam logic [QW-1:0]           Q_MAX    = QW'(2 ** (DW - 1) - 1);
  localparam logic signed [2*DW-1:0]  L_ONE    = (2 * DW)'(2 ** FB);
  localparam logic signed [2*DW-1:0]  L_HW     = (2 * DW)'(SCREEN_WIDTH / 2);
  localparam logic signed [2*DW-1:0]  L_HH     = (2 * DW)'(SCREEN_HEIGHT / 2);
  localparam logic signed [2*DW-1:0]  L_XMAX   = (2 * DW)'(SCREEN_WIDTH - 1);
  localparam logic signed [2*DW-1:0]  L_YMAX   = (2 * DW)'(SCREEN_HEIGHT - 1);

  typedef enum logic [2:0] {S_IDLE, S_DIVIDE, S_MULTIPLY, S_MAP, S_OUTPUT} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic signed [DW-1:0]  r_v [4];
  logic                  r_last;
  logic [CW-1:0]         r_cnt;
  logic [DW:0]           r_rem;
  logic [QW-1:0]         r_quo;
  logic signed [DW-1:0]  r_ndc [3];

  logic                  w_accept;
  logic                  w_w_pos;
  logic signed [DW:0]    w_wext;
  logic [2:0]            w_outside;
  logic                  w_clip;
  logic [DW:0]           w_div;
  logic [DW:0]           w_rem_sh;
  logic [DW:0]           w_rem_next;
  logic                  w_qbit;
  logic signed [DW-1:0]  w_inv;
  logic signed [DW-1:0]  w_ndc [3];
  logic signed [2*DW-1:0] w_xe, w_ye, w_sx, w_sy;
  logic [XW-1:0]         w_px;
  logic [YW-1:0]         w_py;

  assign w_accept = i_dv && o_ready;

  // Clip test on the latched vertex: w must be positive and |x|,|y|,|z| <= w.
  assign w_w_pos = !r_v[3][DW-1] && (r_v[3] != '0);
  assign w_wext  = {r_v[3][DW-1], r_v[3]};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_axis
      logic signed [DW:0]     w_ext;
      logic signed [DW:0]     w_abs;
      logic signed [2*DW-1:0] w_cext;
      logic signed [2*DW-1:0] w_iext;
      logic signed [2*DW-1:0] w_prod;
      logic signed [2*DW-1:0] w_shr;
      logic                   w_fits;

      assign w_ext          = {r_v[gi][DW-1], r_v[gi]};
      assign w_abs          = w_ext[DW] ? -w_ext : w_ext;
      assign w_outside[gi]  = w_abs > w_wext;

      // NDC coordinate: full-width product, arithmetic shift, then saturate.
      assign w_cext  = {{DW{r_v[gi][DW-1]}}, r_v[gi]};
      assign w_iext  = {{DW{w_inv[DW-1]}}, w_inv};
      assign w_prod  = w_cext * w_iext;
      assign w_shr   = w_prod >>> FB;
      assign w_fits  = (&w_shr[2*DW-1:DW-1]) || !(|w_shr[2*DW-1:DW-1]);
      assign w_ndc[gi] = w_fits ? w_shr[DW-1:0]
                       : (w_shr[2*DW-1] ? {1'b1, {(DW-1){1'b0}}}
                                        : {1'b0, {(DW-1){1'b1}}});
    end
  endgenerate

  assign w_clip = !w_w_pos || (|w_outside);

  // One restoring-division step: dividend is 2^(2*FB), so only its MSB is set.
  assign w_div      = {1'b0, r_v[3]};
  assign w_rem_sh   = {r_rem[DW-1:0], (r_cnt == '0)};
  assign w_qbit     = w_rem_sh >= w_div;
  assign w_rem_next = w_qbit ? (w_rem_sh - w_div) : w_rem_sh;

  // Reciprocal: saturate to the largest positive value, zero when w <= 0.
  always_comb begin
    w_inv = '0;
    if (w_w_pos) begin
      if (r_quo > Q_MAX) w_inv = {1'b0, {(DW-1){1'b1}}};
      else               w_inv = r_quo[DW-1:0];
    end
  end

  // Viewport mapping; y is flipped so the top of the screen is row 0.
  assign w_xe = {{DW{r_ndc[0][DW-1]}}, r_ndc[0]};
  assign w_ye = {{DW{r_ndc[1][DW-1]}}, r_ndc[1]};
  assign w_sx = ((w_xe + L_ONE) * L_HW) >>> FB;
  assign w_sy = ((L_ONE - w_ye) * L_HH) >>> FB;

  // Clamp the mapped coordinates onto the screen.
  always_comb begin
    w_px = '0;
    w_py = '0;
    if (w_sx > L_XMAX)       w_px = L_XMAX[XW-1:0];
    else if (!w_sx[2*DW-1])  w_px = w_sx[XW-1:0];
    if (w_sy > L_YMAX)       w_py = L_YMAX[YW-1:0];
    else if (!w_sy[2*DW-1])  w_py = w_sy[YW-1:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and handshake outputs; the divide length never depends on data.
  always_comb begin
    w_state_next = r_state;
    o_ready      = 1'b0;
    o_dv         = 1'b0;
    o_finished   = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_dv) w_state_next = S_DIVIDE;
      end
      S_DIVIDE:   if (r_cnt == DIV_LAST) w_state_next = S_MULTIPLY;
      S_MULTIPLY: w_state_next = S_MAP;
      S_MAP:      w_state_next = S_OUTPUT;
      S_OUTPUT: begin
        o_ready      = 1'b1;
        o_dv         = 1'b1;
        o_finished   = r_last;
        w_state_next = i_dv ? S_DIVIDE : S_IDLE;
      end
      default:    w_state_next = S_IDLE;
    endcase
  end

  // Datapath registers: latch on accept, iterate the divider, hold results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_v[i] <= '0;
      for (int i = 0; i < 3; i++) r_ndc[i] <= '0;
      r_last    <= 1'b0;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      o_x       <= '0;
      o_y       <= '0;
      o_depth   <= '0;
      o_clipped <= 1'b0;
    end else begin
      if (w_accept) begin
        for (int i = 0; i < 4; i++) r_v[i] <= i_vertex[i];
        r_last <= i_last;
        r_cnt  <= '0;
        r_rem  <= '0;
        r_quo  <= '0;
      end else if (r_state == S_DIVIDE) begin
        r_rem <= w_rem_next;
        r_quo <= {r_quo[QW-2:0], w_qbit};
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == S_MULTIPLY) begin
        for (int i = 0; i < 3; i++) r_ndc[i] <= w_ndc[i];
      end else if (r_state == S_MAP) begin
        o_x       <= w_px;
        o_y       <= w_py;
        o_depth   <= r_ndc[2];
        o_clipped <= w_clip;
      end
    end
  end

endmodule

// File: tb/tb_vertex_post_processor.sv
// Randomized and directed checks of vertex_post_processor against an
// arithmetic reference model (plain division, shifts and clamps).
module tb_vertex_post_processor;

  logic                clk = 1'b0;
  logic                rst;
  logic signed [17:0]  i_vertex [4];
  logic                i_dv;
  logic                i_last;
  logic                o_ready;
  logic [8:0]          o_x;
  logic [7:0]          o_y;
  logic signed [17:0]  o_depth;
  logic                o_clipped;
  logic                o_dv;
  logic                o_finished;

  vertex_post_processor #(
    .DATAWIDTH(18), .FRACBITS(12), .SCREEN_WIDTH(320), .SCREEN_HEIGHT(240)
  ) dut (
    .clk(clk), .rst(rst), .i_vertex(i_vertex), .i_dv(i_dv), .i_last(i_last),
    .o_ready(o_ready), .o_x(o_x), .o_y(o_y), .o_depth(o_depth),
    .o_clipped(o_clipped), .o_dv(o_dv), .o_finished(o_finished)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x, y, z, w;
    bit last;
    int ex, ey, ed;
    bit ec;
    bit has_lit;
    int lx, ly, ld;
    bit lc;
    bit gap;
    int acc_cyc;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_acc = 0;
  int   n_drop = 0;
  int   n_dv = 0;
  int   last_dv_cyc = 0;
  int   hx = 0, hy = 0, hd = 0;
  bit   hc = 0;

  bit   lit_valid = 0;
  int   lit_x, lit_y, lit_d;
  bit   lit_c;
  bit   lit_gap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat18(input longint v);
    if (v > 131071)  return 131071;
    if (v < -131072) return -131072;
    return int'(v);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: exact integer reciprocal, NDC, viewport, clip rules.
  function automatic void model(input int x, input int y, input int z, input int w,
                                output int ex, output int ey, output int ed,
                                output bit ec);
    longint inv, xn, yn, sx, sy;
    if (w > 0) begin
      inv = (longint'(1) << 24) / longint'(w);
      if (inv > 131071) inv = 131071;
    end else begin
      inv = 0;
    end
    xn = sat18((longint'(x) * inv) >>> 12);
    yn = sat18((longint'(y) * inv) >>> 12);
    ed = sat18((longint'(z) * inv) >>> 12);
    sx = ((xn + 4096) * 160) >>> 12;
    sy = ((4096 - yn) * 120) >>> 12;
    if (sx < 0) sx = 0;
    if (sx > 319) sx = 319;
    if (sy < 0) sy = 0;
    if (sy > 239) sy = 239;
    ex = int'(sx);
    ey = int'(sy);
    ec = (w <= 0) || (iabs(x) > w) || (iabs(y) > w) || (iabs(z) > w);
  endfunction

  // Single compare process: retire outputs, check hold, then log accepts.
  always @(negedge clk) begin
    if (rst) begin
      n_drop += q.size();
      q.delete();
      hx = 0; hy = 0; hd = 0; hc = 0;
    end else begin
      if (o_dv) begin
        n_dv++;
        if (q.size() == 0) begin
          chk("spurious_dv", 1, 0);
        end else begin
          ent_t e;
          e = q.pop_front();
          $display("vertex (%0d,%0d,%0d,%0d) -> x=%0d y=%0d depth=%0d clip=%0d fin=%0d",
                   e.x, e.y, e.z, e.w, o_x, o_y, o_depth, o_clipped, o_finished);
          chk("latency", cyc - e.acc_cyc, 28);
          chk("o_x", o_x, e.ex);
          chk("o_y", o_y, e.ey);
          chk("o_depth", o_depth, e.ed);
          chk("o_clipped", o_clipped, e.ec);
          chk("o_finished", o_finished, e.last);
          if (e.has_lit) begin
            chk("lit_o_x", o_x, e.lx);
            chk("lit_o_y", o_y, e.ly);
            chk("lit_o_depth", o_depth, e.ld);
            chk("lit_o_clipped", o_clipped, e.lc);
          end
          if (e.gap) chk("dv_spacing", cyc - last_dv_cyc, 28);
        end
        last_dv_cyc = cyc;
        hx = o_x; hy = o_y; hd = o_depth; hc = o_clipped;
      end else begin
        if (o_finished) chk("finished_without_dv", 1, 0);
        if (o_x != hx || o_y != hy || o_depth != hd || o_clipped != hc)
          chk("hold_outputs", 1, 0);
      end
      if (i_dv && o_ready) begin
        ent_t e;
        e.x = i_vertex[0]; e.y = i_vertex[1]; e.z = i_vertex[2]; e.w = i_vertex[3];
        e.last = i_last;
        model(e.x, e.y, e.z, e.w, e.ex, e.ey, e.ed, e.ec);
        e.has_lit = lit_valid;
        e.lx = lit_x; e.ly = lit_y; e.ld = lit_d; e.lc = lit_c;
        e.gap = lit_gap;
        e.acc_cyc = cyc;
        q.push_back(e);
        n_acc++;
      end
    end
  end

  // Present a vertex and wait (bounded) until it is taken.
  task automatic send(input int x, input int y, input int z, input int w,
                      input bit last, input bit hold_dv);
    bit taken;
    taken = 0;
    i_vertex[0] = 18'(x); i_vertex[1] = 18'(y);
    i_vertex[2] = 18'(z); i_vertex[3] = 18'(w);
    i_last = last;
    i_dv = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (o_ready) begin
        taken = 1;
        break;
      end
    end
    if (!taken) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!hold_dv) i_dv = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  task automatic send_lit(input int x, input int y, input int z, input int w,
                          input int ex, input int ey, input int ed, input bit ec);
    lit_valid = 1; lit_x = ex; lit_y = ey; lit_d = ed; lit_c = ec;
    send(x, y, z, w, 1'b0, 1'b0);
    lit_valid = 0;
    drain();
  endtask

  int rx, ry, rz, rw;

  function automatic int rand_coord(input int w);
    int v;
    if (w <= 0) return int'($urandom_range(0, 100000)) - 50000;
    if ($urandom_range(0, 4) == 0) begin
      v = w + int'($urandom_range(1, 1000));
      if (v > 131071) v = 131071;
      return ($urandom_range(0, 1) == 1) ? -v : v;
    end
    return int'($urandom_range(0, 2 * w)) - w;
  endfunction

  initial begin
    rst = 1'b1;
    i_dv = 1'b0;
    i_last = 1'b0;
    for (int i = 0; i < 4; i++) i_vertex[i] = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_o_ready", o_ready, 1);
    chk("rst_o_dv", o_dv, 0);
    chk("rst_o_finished", o_finished, 0);
    chk("rst_o_clipped", o_clipped, 0);
    chk("rst_o_x", o_x, 0);
    chk("rst_o_y", o_y, 0);
    chk("rst_o_depth", o_depth, 0);
    @(posedge clk);
    #1;

    // Directed vertices with hand-computed results.
    send_lit(2048, 0, 2048, 4096, 240, 120, 2048, 0);
    send_lit(-8192, 4096, 0, 8192, 0, 60, 0, 0);
    send_lit(4096, 0, 0, 4096, 319, 120, 0, 0);
    send_lit(4100, 0, 0, 4096, 319, 120, 0, 1);
    send_lit(0, 0, 0, 0, 160, 120, 0, 1);
    send_lit(100, 200, 300, -4096, 160, 120, 0, 1);
    send_lit(0, 0, 0, 1, 160, 120, 0, 0);

    // Reset while the divider is running: that vertex must never appear.
    send(1000, 500, 0, 4096, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", o_ready, 1);
    chk("dv_after_rst", o_dv, 0);
    chk("x_after_rst", o_x, 0);
    repeat (40) @(posedge clk);
    #1;

    // Three back-to-back vertices with i_dv held; only the third is last.
    send(1024, -1024, 512, 4096, 1'b0, 1'b1);
    lit_gap = 1;
    send(-3000, 2000, -100, 6000, 1'b0, 1'b1);
    send(500, 500, 500, 1000, 1'b1, 1'b0);
    lit_gap = 0;
    drain();

    // Randomized traffic with occasional back-to-back issue.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0:       rw = -int'($urandom_range(0, 50000));
        1:       rw = int'($urandom_range(1, 200));
        default: rw = int'($urandom_range(256, 60000));
      endcase
      rx = rand_coord(rw);
      ry = rand_coord(rw);
      rz = rand_coord(rw);
      send(rx, ry, rz, rw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (i_dv == 1'b0) repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
    end
    i_dv = 1'b0;
    drain();
    repeat (5) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    chk("dv_count", n_dv, n_acc - n_drop);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
